// File: rtl/seq_addsub.sv
// Sequential chunked adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// and publishes sum, carry-out and signed overflow when the last chunk completes.
module seq_addsub #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [CHUNK:0]   chunk_s;
    logic             cin_msb_s;

    assign last_s = (cnt_r == CW'(NCH - 1));

    // Chunk adder; operands shift down so the active chunk is always at the bottom.
    always_comb begin
        chunk_s   = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
        // Finished chunks enter at the top and drift down to their final position.
        acc_nx_s  = (acc_r >> CHUNK) | (WIDTH'(chunk_s[CHUNK-1:0]) << (WIDTH - CHUNK));
        // Carry into the top bit of this chunk, recovered from its sum bit.
        cin_msb_s = chunk_s[CHUNK-1] ^ a_r[CHUNK-1] ^ b_r[CHUNK-1];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and datapath control.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand capture, chunk stepping and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            a_r     <= x;
            b_r     <= y ^ {WIDTH{sel}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= sel;
            cnt_r   <= {CW{1'b0}};
        end else if (step_s) begin
            a_r     <= a_r >> CHUNK;
            b_r     <= b_r >> CHUNK;
            acc_r   <= acc_nx_s;
            carry_r <= chunk_s[CHUNK];
            cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + CW'(1);
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            acc_r   <= acc_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Registered status and result; results only move on the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_nx_s == BUSY);
            done <= (state_nx_s == DONE);
            if (step_s && last_s) begin
                sum      <= acc_nx_s;
                c_out    <= chunk_s[CHUNK];
                overflow <= chunk_s[CHUNK] ^ cin_msb_s;
            end else begin
                sum      <= sum;
                c_out    <= c_out;
                overflow <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: a 6-bit/2-bit-chunk instance and an 8-bit single-chunk instance.
module tb_seq_addsub;

    localparam int NCH = 3;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       ov;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [5:0] x = 6'd0;
    logic [5:0] y = 6'd0;
    logic       busy, done, c_out, overflow;
    logic [5:0] sum;

    logic       start8 = 1'b0;
    logic       sel8 = 1'b0;
    logic [7:0] x8 = 8'd0;
    logic [7:0] y8 = 8'd0;
    logic       busy8, done8, c_out8, overflow8;
    logic [7:0] sum8;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t q8[$];

    seq_addsub #(.WIDTH(6), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .x(x), .y(y),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular and signed integer arithmetic.
    function automatic exp_t model(input longint ux, input longint uy, input bit s, input int w);
        exp_t   e;
        longint m, sx, sy, r;
        m  = longint'(1) << w;
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        if (s) begin
            e.sum = 8'((ux - uy + m) % m);
            e.c   = (ux >= uy);
            r     = sx - sy;
        end else begin
            e.sum = 8'((ux + uy) % m);
            e.c   = (ux + uy >= m);
            r     = sx + sy;
        end
        e.ov  = (r >= m / 2) || (r < -(m / 2));
        e.cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic [5:0] ix, input logic [5:0] iy, input logic isel, input bit junk);
        exp_t e;
        @(negedge clk);
        start = 1'b1; x = ix; y = iy; sel = isel;
        @(posedge clk);
        #1;
        e = model(longint'(ix), longint'(iy), isel, 6);
        e.cyc = cyc + NCH;
        q.push_back(e);
        repeat (NCH) begin
            @(negedge clk);
            if (junk) begin
                start = 1'b1;
                x = 6'($urandom());
                y = 6'($urandom());
                sel = 1'($urandom());
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic issue8(input logic [7:0] ix, input logic [7:0] iy, input logic isel);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; x8 = ix; y8 = iy; sel8 = isel;
        @(posedge clk);
        #1;
        e = model(longint'(ix), longint'(iy), isel, 8);
        e.cyc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
    endtask

    // Monitor for the 6-bit instance: result, latency, busy length, result hold.
    exp_t last = '{8'd0, 1'b0, 1'b0, 0};
    int   run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run  = 0;
            last = '{8'd0, 1'b0, 1'b0, 0};
        end else begin
            if (busy) begin
                run++;
                chk("hold_during_busy", int'({c_out, overflow, sum}), int'({last.c, last.ov, last.sum[5:0]}));
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", int'(sum), int'(e.sum));
                    chk("c_out", int'(c_out), int'(e.c));
                    chk("overflow", int'(overflow), int'(e.ov));
                    chk("done_latency", cyc, e.cyc);
                    chk("busy_cycles", run, NCH);
                    last = e;
                end
                run = 0;
            end
        end
    end

    // Monitor for the 8-bit single-chunk instance.
    int run8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run8 = 0;
        end else begin
            if (busy8) run8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", int'(sum8), int'(e.sum));
                    chk("c_out8", int'(c_out8), int'(e.c));
                    chk("overflow8", int'(overflow8), int'(e.ov));
                    chk("done_latency8", cyc, e.cyc);
                    chk("busy_cycles8", run8, 1);
                end
                run8 = 0;
            end
        end
    end

    initial begin
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'({c_out, overflow, sum}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(6'd5, 6'd3, 1'b0, 1'b0);
        idle(2);
        issue(6'd31, 6'd1, 1'b0, 1'b0);
        idle(1);
        issue(6'd5, 6'd7, 1'b1, 1'b0);
        issue(6'h20, 6'd1, 1'b1, 1'b0);
        idle(2);
        issue(6'd10, 6'd20, 1'b0, 1'b1);
        idle(2);

        // Abort an operation in its second busy cycle.
        @(negedge clk);
        start = 1'b1; x = 6'd9; y = 6'd4; sel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'({c_out, overflow, sum}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_idle", int'({busy, done}), 0);
        issue(6'd1, 6'd1, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            issue(6'($urandom()), 6'($urandom()), 1'($urandom()), ($urandom_range(3, 0) == 0));
            if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
        end
        idle(2);

        issue8(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            issue8(8'($urandom()), 8'($urandom()), 1'($urandom()));
        end
        @(negedge clk);
        start8 = 1'b0;

        for (int i = 0; i < 20 && (q.size() != 0 || q8.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", q.size() + q8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 6: operand/result width in bits.
REQ-002 Parameter CHUNK, default 2: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1; NCH = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 sel  input  1  0 = add (x+y), 1 = subtract (x-y); sampled with start.
REQ-007 x  input  WIDTH  two's-complement operand A; sampled with start.
REQ-008 y  input  WIDTH  two's-complement operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 sum  output  WIDTH  result, two's complement.
REQ-012 c_out  output  1  carry out of MSB.
REQ-013 overflow  output  1  signed overflow flag.

Function
REQ-014 FSM states IDLE, BUSY, DONE; busy=1 exactly in BUSY; done=1 exactly in DONE.
REQ-015 IDLE: start=1 on an edge -> capture x, y^{WIDTH{sel}}, carry-in=sel, chunk counter=0, go to BUSY; start=0 -> stay IDLE.
REQ-016 BUSY: each edge adds chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1, LSB chunk first) with running carry into an internal accumulator; counter increments.
REQ-017 BUSY: on the edge processing chunk NCH-1 -> go to DONE; sum, c_out, overflow update on that same edge.
REQ-018 Latency: done high in the cycle following the (NCH+1)-th edge counted from the edge sampling start (inclusive); busy high for exactly NCH cycles.
REQ-019 DONE lasts one cycle; start=1 -> new capture and BUSY (back-to-back, no IDLE gap); else -> IDLE.
REQ-020 start during BUSY is ignored; operands, sel and in-flight result are unaffected.
REQ-021 c_out = carry out of bit WIDTH-1 of x + (y^{WIDTH{sel}}) + sel; on subtract, c_out=1 means no borrow.
REQ-022 overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 sum, c_out, overflow are registered and hold their values from completion until the next completion; no partial results are visible on them during BUSY.
REQ-024 Results are modulo 2^WIDTH; no saturation.

Reset
REQ-025 rst_n=0 asynchronously forces IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, counter=0, internal accumulator=0.
REQ-026 Reset asserted mid-operation aborts it; no done pulse follows; first start after rst_n rises is accepted normally.
REQ-027 rst_n deassertion does not itself start an operation.

Verification (WIDTH=6, CHUNK=2 unless stated)
REQ-028 x=5, y=3, sel=0 -> sum=6'b001000, c_out=0, overflow=0; busy 3 cycles, done on the 4th cycle after the start edge.
REQ-029 x=31, y=1, sel=0 -> sum=6'b100000, c_out=0, overflow=1.
REQ-030 x=5, y=7, sel=1 -> sum=6'b111110 (-2), c_out=0, overflow=0; then back-to-back start in DONE with x=-32, y=1, sel=1 -> sum=6'b011111, c_out=1, overflow=1, no IDLE cycle between operations.
REQ-031 start held high and operands changed throughout BUSY -> result reflects only the originally captured operands; exactly one done pulse per accepted start.
REQ-032 rst_n pulsed low during 2nd BUSY cycle -> all outputs 0 immediately, no done pulse; next start x=1, y=1, sel=0 -> sum=2.
REQ-033 WIDTH=8, CHUNK=8: x=8'hFF, y=8'h01, sel=0 -> sum=8'h00, c_out=1, overflow=0; busy exactly 1 cycle.
